pow_n_pipe: RTL



---
 rtl/pow_n_pipe.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pow_n_pipe.sv
`default_nettype none
// ============================================================================
// Module      : pow_n_pipe
// Description : Elastic, fully pipelined n^POWER mod 2^WIDTH unit.
//               One multiply per stage (POWER-1 stages), valid/ready on both
//               sides, a side-band tag carried with every sample and a sticky
//               per-sample overflow flag raised when any product needed more
//               than WIDTH bits.
// Ports       : clock      - rising-edge clock
//               reset      - synchronous, active-high reset
//               in_valid   - input sample present
//               in_ready   - unit accepts the sample this cycle
//               in_n       - unsigned base operand
//               in_tag     - tag, passed through unchanged
//               out_valid  - result present (registered)
//               out_ready  - consumer takes the result this cycle
//               out_pow    - in_n^POWER truncated to WIDTH bits (registered)
//               out_tag    - tag of the sample (registered)
//               out_ovf    - 1 if any product exceeded WIDTH bits (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module pow_n_pipe #(
    parameter int WIDTH = 18,
    parameter int POWER = 5,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_n,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pow,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf
);

    localparam int c_STAGES = POWER - 1;

    // Stage registers, stage 1 is nearest the input
    logic [c_STAGES:1]  r_v;
    logic [c_STAGES:1]  r_ovf;
    logic [WIDTH-1:0]   r_n   [1:c_STAGES];
    logic [WIDTH-1:0]   r_p   [1:c_STAGES];
    logic [TAG_W-1:0]   r_tag [1:c_STAGES];

    // Per-stage source selection and full-width product
    logic [c_STAGES:1]  w_rdy;
    logic [c_STAGES:1]  w_src_v;
    logic [c_STAGES:1]  w_src_ovf;
    logic [WIDTH-1:0]   w_src_n   [1:c_STAGES];
    logic [TAG_W-1:0]   w_src_tag [1:c_STAGES];
    logic [2*WIDTH-1:0] w_prod    [1:c_STAGES];
    logic               w_accept;
    logic               w_unused;

    assign in_ready = w_rdy[1] & ~reset;
    assign w_accept = in_valid & in_ready;

    generate
        for (genvar s = 1; s <= c_STAGES; s++) begin : g_stage
            // A stage can load when the consumer takes the output or when
            // any stage from here to the output is empty: the recursive
            // ready chain flattened so each bit depends only on registers
            // and out_ready (bubbles ahead always absorb the advance).
            assign w_rdy[s] = out_ready | ~(&r_v[c_STAGES:s]);

            if (s == 1) begin : g_first
                assign w_src_v[s]   = w_accept;
                assign w_src_n[s]   = in_n;
                assign w_src_tag[s] = in_tag;
                assign w_src_ovf[s] = 1'b0;
                assign w_prod[s]    = {{WIDTH{1'b0}}, in_n} * {{WIDTH{1'b0}}, in_n};
            end else begin : g_rest
                assign w_src_v[s]   = r_v[s-1];
                assign w_src_n[s]   = r_n[s-1];
                assign w_src_tag[s] = r_tag[s-1];
                assign w_src_ovf[s] = r_ovf[s-1];
                assign w_prod[s]    = {{WIDTH{1'b0}}, r_p[s-1]} * {{WIDTH{1'b0}}, r_n[s-1]};
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_v   <= '0;
            r_ovf <= '0;
            for (int s = 1; s <= c_STAGES; s++) begin
                r_n[s]   <= '0;
                r_p[s]   <= '0;
                r_tag[s] <= '0;
            end
        end else begin
            for (int s = 1; s <= c_STAGES; s++) begin
                if (w_rdy[s]) begin
                    r_v[s] <= w_src_v[s];
                    // Data only moves with a valid sample, so an idle input
                    // (possibly X) never reaches the stage registers.
                    if (w_src_v[s]) begin
                        r_n[s]   <= w_src_n[s];
                        r_p[s]   <= w_prod[s][WIDTH-1:0];
                        r_tag[s] <= w_src_tag[s];
                        r_ovf[s] <= w_src_ovf[s] | (|w_prod[s][2*WIDTH-1:WIDTH]);
                    end
                end
            end
        end
    end

    // The last stage's copy of n has no consumer beyond the pipe
    assign w_unused = ^r_n[c_STAGES];

    assign out_valid = r_v[c_STAGES];
    assign out_pow   = r_p[c_STAGES];
    assign out_tag   = r_tag[c_STAGES];
    assign out_ovf   = r_ovf[c_STAGES];

endmodule
`default_nettype wire
